// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_det_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          DEF_WIDTH   = 8;
    localparam int          DEF_PAT_LEN = 5;
    localparam logic [4:0]  DEF_PATTERN = 5'b11011;

    // Counter width able to hold 0..width inclusive
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_det_piso.sv
// Parallel-in serial-out word register, MSB first, with last-bit flag.
// Latency: bit_o reflects the current index combinationally; index advances on shift.
// Backpressure: shift is a plain enable; holding it low stalls the word in place.
module seq_det_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_o,
    output logic             last_o
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] word_q;
    logic [IDX_W-1:0] idx_q;

    // Word capture on load; index walks from MSB down to 0 on each shift
    always_ff @(posedge clk_i) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            word_q <= data;
            idx_q  <= IDX_W'(WIDTH - 1);
        end else if (shift && (idx_q != '0)) begin
            idx_q  <= idx_q - IDX_W'(1);
        end
    end

    assign bit_o  = word_q[idx_q];
    assign last_o = (idx_q == '0);

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: scans a loaded word MSB first and counts PATTERN hits.
// Latency: bits consumed T+1..T+WIDTH after set_i at T; match_o one cycle after the completing bit; done_o at T+WIDTH+1.
// Backpressure: en_i low stalls the scan with all state held; set_i restarts at any time.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 WIDTH   = DEF_WIDTH,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 OVERLAP = 1,
    localparam int                CNT_W   = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic             match_o,
    output logic             detect_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             done_o
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("seq_detector_param: WIDTH must be in 2..32");
    end
    if (PAT_LEN < 1 || PAT_LEN > WIDTH) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN must be in 1..WIDTH");
    end

    state_t              state_q;
    logic [PAT_LEN-1:0]  hist_q;
    logic [FILL_W-1:0]   fill_q;
    logic [PAT_LEN:0]    hist_shift;
    logic [PAT_LEN-1:0]  hist_nxt;
    logic [FILL_W-1:0]   fill_nxt;
    logic                hit;
    logic                consume;
    logic                piso_bit;
    logic                piso_last;

    // A bit is taken only while scanning, enabled, and not being restarted
    assign consume = (state_q == SHIFT) && en_i && !set_i;

    seq_det_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk_i  (clk_i),
        .rst    (rst_i),
        .load   (set_i),
        .shift  (consume),
        .data   (data_i),
        .bit_o  (piso_bit),
        .last_o (piso_last)
    );

    // Next history/fill if the current bit is consumed, and whether that completes the pattern
    always_comb begin
        hist_shift = {hist_q, piso_bit};
        hist_nxt   = hist_shift[PAT_LEN-1:0];
        fill_nxt   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit        = (fill_nxt == FILL_FULL) && (hist_nxt == PATTERN);
    end

    // Scan FSM with registered status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hist_q      <= '0;
            fill_q      <= '0;
            busy_o      <= 1'b0;
            match_o     <= 1'b0;
            detect_o    <= 1'b0;
            match_cnt_o <= '0;
            done_o      <= 1'b0;
        end else begin
            match_o <= 1'b0;
            done_o  <= 1'b0;
            if (set_i) begin
                state_q     <= SHIFT;
                hist_q      <= '0;
                fill_q      <= '0;
                busy_o      <= 1'b1;
                detect_o    <= 1'b0;
                match_cnt_o <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    SHIFT: begin
                        if (en_i) begin
                            hist_q <= hist_nxt;
                            // Non-overlapping mode forgets history once a match lands
                            fill_q <= (hit && (OVERLAP == 0)) ? '0 : fill_nxt;
                            if (hit) begin
                                match_o     <= 1'b1;
                                detect_o    <= 1'b1;
                                match_cnt_o <= match_cnt_o + CNT_W'(1);
                            end
                            if (piso_last) begin
                                state_q <= DONE;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
